// File: rtl/ascon_ctrl_fsm.sv
// rtl/ascon_ctrl_fsm.sv - Ascon AEAD control sequencer (optional decrypt mode: ASCON_CTRL_DECRYPT_EN)
module ascon_ctrl_fsm #(
  parameter int NB_AD    = 1,
  parameter int NB_PT    = 4,
  parameter int ROUNDS_A = 12,
  parameter int ROUNDS_B = 6
) (
  input  logic       clock_i,
  input  logic       resetb_i,
  input  logic       start_i,
`ifdef ASCON_CTRL_DECRYPT_EN
  input  logic       decrypt_i,
  output logic       ct_replace_o,
`endif
  input  logic       data_valid_i,
  output logic       data_ready_o,
  output logic [3:0] round_o,
  output logic       init_select_o,
  output logic       ena_reg_state_o,
  output logic       round_bypass_o,
  output logic       ena_xor_up_o,
  output logic       ena_xor_down_o,
  output logic [1:0] conf_xor_down_o,
  output logic       cipher_valid_o,
  output logic [3:0] block_idx_o,
  output logic       tag_valid_o,
  output logic       end_o,
  output logic       busy_o
);

  localparam logic [3:0] RND_A0      = 4'(12 - ROUNDS_A);
  localparam logic [3:0] RND_B0      = 4'(12 - ROUNDS_B);
  localparam logic [3:0] RND_LAST    = 4'd11;
  localparam logic [3:0] BLK_AD_LAST = 4'(NB_AD - 1);
  localparam logic [3:0] BLK_PT_LAST = 4'(NB_PT - 1);
  localparam bit         HAS_AD      = (NB_AD > 0);

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD, S_PERM_A, S_WAIT_AD, S_PERM_AD,
    S_WAIT_PT, S_PERM_PT, S_PERM_F, S_DONE
  } state_t;

  state_t     r_state;
  logic [3:0] r_round;
  logic [3:0] r_blk;
  logic       r_dec;

  logic w_last;
  logic w_accept;
  logic w_accept_pt;
  logic w_final_pt;
  logic w_xdn_a;
  logic w_xdn_ad;
  logic w_xdn_f;

  // Sequencer: state, round counter and block counter advance together
  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      r_state <= S_IDLE;
      r_round <= 4'd0;
      r_blk   <= 4'd0;
      r_dec   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_state <= S_LOAD;
            r_round <= RND_A0;
            r_blk   <= 4'd0;
`ifdef ASCON_CTRL_DECRYPT_EN
            r_dec   <= decrypt_i;
`else
            r_dec   <= 1'b0;
`endif
          end
        end
        S_LOAD, S_PERM_A: begin
          if (r_round == RND_LAST) begin
            r_state <= HAS_AD ? S_WAIT_AD : S_WAIT_PT;
            r_round <= RND_B0;
          end else begin
            r_state <= S_PERM_A;
            r_round <= r_round + 4'd1;
          end
        end
        S_WAIT_AD, S_PERM_AD: begin
          if (r_state == S_PERM_AD || data_valid_i) begin
            if (r_round == RND_LAST) begin
              r_round <= RND_B0;
              if (r_blk == BLK_AD_LAST) begin
                r_state <= S_WAIT_PT;
                r_blk   <= 4'd0;
              end else begin
                r_state <= S_WAIT_AD;
                r_blk   <= r_blk + 4'd1;
              end
            end else begin
              r_state <= S_PERM_AD;
              r_round <= r_round + 4'd1;
            end
          end
        end
        S_WAIT_PT, S_PERM_PT: begin
          if (r_state == S_WAIT_PT && data_valid_i && r_blk == BLK_PT_LAST) begin
            // final block skips p^b and heads straight into finalisation
            r_state <= S_PERM_F;
            r_round <= RND_A0;
          end else if (r_state == S_PERM_PT || data_valid_i) begin
            if (r_round == RND_LAST) begin
              r_state <= S_WAIT_PT;
              r_round <= RND_B0;
              r_blk   <= r_blk + 4'd1;
            end else begin
              r_state <= S_PERM_PT;
              r_round <= r_round + 4'd1;
            end
          end
        end
        S_PERM_F: begin
          if (r_round == RND_LAST) begin
            r_state <= S_DONE;
            r_round <= 4'd0;
          end else begin
            r_round <= r_round + 4'd1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_round <= 4'd0;
          r_blk   <= 4'd0;
        end
        default: begin
          r_state <= S_IDLE;
          r_round <= 4'd0;
          r_blk   <= 4'd0;
        end
      endcase
    end
  end

  // Datapath controls decoded from state and counters (ready also from valid)
  always_comb begin
    w_last      = (r_round == RND_LAST);
    w_accept    = (r_state == S_WAIT_AD || r_state == S_WAIT_PT) && data_valid_i;
    w_accept_pt = (r_state == S_WAIT_PT) && data_valid_i;
    w_final_pt  = w_accept_pt && (r_blk == BLK_PT_LAST);
    w_xdn_a     = (r_state == S_LOAD || r_state == S_PERM_A) && w_last;
    w_xdn_ad    = ((r_state == S_WAIT_AD && data_valid_i) || r_state == S_PERM_AD)
                  && w_last && (r_blk == BLK_AD_LAST);
    w_xdn_f     = (r_state == S_PERM_F) && w_last;

    data_ready_o    = w_accept;
    round_o         = r_round;
    block_idx_o     = r_blk;
    init_select_o   = (r_state == S_LOAD);
    ena_reg_state_o = w_accept || r_state == S_LOAD || r_state == S_PERM_A ||
                      r_state == S_PERM_AD || r_state == S_PERM_PT || r_state == S_PERM_F;
    round_bypass_o  = w_final_pt;
    // in decrypt mode the ciphertext overwrites the rate instead of being XORed in
    ena_xor_up_o    = w_accept && !(w_accept_pt && r_dec);
    ena_xor_down_o  = w_xdn_a || w_xdn_ad || w_final_pt || w_xdn_f;
    if (w_xdn_a)         conf_xor_down_o = HAS_AD ? 2'd0 : 2'd3;
    else if (w_xdn_ad)   conf_xor_down_o = 2'd1;
    else if (w_final_pt) conf_xor_down_o = 2'd2;
    else                 conf_xor_down_o = 2'd0;
    cipher_valid_o  = w_accept_pt;
    tag_valid_o     = (r_state == S_DONE);
    end_o           = (r_state == S_DONE);
    busy_o          = (r_state != S_IDLE);
`ifdef ASCON_CTRL_DECRYPT_EN
    ct_replace_o    = w_accept_pt && r_dec;
`endif
  end

endmodule

// File: tb/tb_ascon_ctrl_fsm.sv
// tb/tb_ascon_ctrl_fsm.sv - randomized self-checking bench for ascon_ctrl_fsm
module tb_ascon_ctrl_fsm;

  logic clock_i = 1'b0;
  always #5 clock_i = ~clock_i;

  logic       resetb;
  logic       dv;
  logic       st[3];
  logic       dr[3], init[3], ereg[3], byp[3], xup[3], xdn[3], cv[3];
  logic       tagv[3], endp[3], busy[3], ct[3];
  logic [3:0] rnd[3], blk[3];
  logic [1:0] conf[3];
  logic [23:0] obs[3];
`ifdef ASCON_CTRL_DECRYPT_EN
  logic       dec;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int sel = 0;
  int cyc = 0;
  int abort_at = -1;
  bit aborted = 0;
  int n_cv = 0;
  int end_cyc = -1;
  int n_stall = 0;

  localparam logic [23:0] FULL = 24'hFFFFFF;
  localparam logic [23:0] DONE_MASK = 24'hFFFFFF ^ 24'h078078;

  // expected/observed output word: {ctr, ready, round, init, ereg, bypass, xup, xdn, conf, cv, blk, tag, end, busy}
  function automatic logic [23:0] pk(bit a_dr, int a_rnd, bit a_init, bit a_ereg, bit a_byp,
                                     bit a_xup, bit a_xdn, int a_conf, bit a_cv, int a_blk,
                                     bit a_tag, bit a_end, bit a_busy, bit a_ctr);
    return {3'b000, a_ctr, a_dr, 4'(a_rnd), a_init, a_ereg, a_byp, a_xup, a_xdn,
            2'(a_conf), a_cv, 4'(a_blk), a_tag, a_end, a_busy};
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_obs
    assign obs[g] = pk(dr[g], int'(rnd[g]), init[g], ereg[g], byp[g], xup[g], xdn[g],
                       int'(conf[g]), cv[g], int'(blk[g]), tagv[g], endp[g], busy[g], ct[g]);
`ifndef ASCON_CTRL_DECRYPT_EN
    assign ct[g] = 1'b0;
`endif
  end

  ascon_ctrl_fsm u_dut0 (
    .clock_i(clock_i), .resetb_i(resetb), .start_i(st[0]),
`ifdef ASCON_CTRL_DECRYPT_EN
    .decrypt_i(dec), .ct_replace_o(ct[0]),
`endif
    .data_valid_i(dv), .data_ready_o(dr[0]), .round_o(rnd[0]), .init_select_o(init[0]),
    .ena_reg_state_o(ereg[0]), .round_bypass_o(byp[0]), .ena_xor_up_o(xup[0]),
    .ena_xor_down_o(xdn[0]), .conf_xor_down_o(conf[0]), .cipher_valid_o(cv[0]),
    .block_idx_o(blk[0]), .tag_valid_o(tagv[0]), .end_o(endp[0]), .busy_o(busy[0])
  );

  ascon_ctrl_fsm #(.NB_AD(2), .NB_PT(3), .ROUNDS_A(4), .ROUNDS_B(8)) u_dut1 (
    .clock_i(clock_i), .resetb_i(resetb), .start_i(st[1]),
`ifdef ASCON_CTRL_DECRYPT_EN
    .decrypt_i(dec), .ct_replace_o(ct[1]),
`endif
    .data_valid_i(dv), .data_ready_o(dr[1]), .round_o(rnd[1]), .init_select_o(init[1]),
    .ena_reg_state_o(ereg[1]), .round_bypass_o(byp[1]), .ena_xor_up_o(xup[1]),
    .ena_xor_down_o(xdn[1]), .conf_xor_down_o(conf[1]), .cipher_valid_o(cv[1]),
    .block_idx_o(blk[1]), .tag_valid_o(tagv[1]), .end_o(endp[1]), .busy_o(busy[1])
  );

  ascon_ctrl_fsm #(.NB_AD(0), .NB_PT(1), .ROUNDS_A(12), .ROUNDS_B(6)) u_dut2 (
    .clock_i(clock_i), .resetb_i(resetb), .start_i(st[2]),
`ifdef ASCON_CTRL_DECRYPT_EN
    .decrypt_i(dec), .ct_replace_o(ct[2]),
`endif
    .data_valid_i(dv), .data_ready_o(dr[2]), .round_o(rnd[2]), .init_select_o(init[2]),
    .ena_reg_state_o(ereg[2]), .round_bypass_o(byp[2]), .ena_xor_up_o(xup[2]),
    .ena_xor_down_o(xdn[2]), .conf_xor_down_o(conf[2]), .cipher_valid_o(cv[2]),
    .block_idx_o(blk[2]), .tag_valid_o(tagv[2]), .end_o(endp[2]), .busy_o(busy[2])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h dut=%0d cyc=%0d t=%0t", tag, got, exp, sel, cyc, $time);
    end
  endtask

  function automatic bit rbit();
    return 1'($urandom_range(1));
  endfunction

  // one clock cycle: drive inputs, compare outputs mid-cycle, advance past next edge
  task automatic step(input bit st_in, input bit dv_in, input logic [23:0] exp,
                      input logic [23:0] mask, input string tag);
    if (aborted) return;
    for (int i = 0; i < 3; i++) st[i] = (i == sel) ? st_in : 1'b0;
    dv = dv_in;
    if (cyc == abort_at) begin
      resetb = 1'b0;
      st[sel] = 1'b0;
      #1;
      check({tag, "_reset"}, {8'h0, obs[sel]}, 32'h0);
      aborted = 1;
      return;
    end
    #1;
    check(tag, {8'h0, obs[sel] & mask}, {8'h0, exp & mask});
    if (obs[sel][7]) n_cv++;
    if (obs[sel][1]) end_cyc = cyc;
    @(posedge clock_i);
    #1;
    cyc++;
  endtask

  // one AD or PT block: optional stalls, then accept cycle and the rest of p^b
  task automatic do_block(input bit is_pt, input int b, input int rb, input bit ad_last,
                          input bit final_pt, input int stall_pct, input int forced, input bit d);
    int k;
    logic [23:0] e_wait;
    bit acc;
    bit x;
    e_wait = pk(0, 12 - rb, 0, 0, 0, 0, 0, 0, 0, b, 0, 0, 1, 0);
    for (int i = 0; i < forced; i++) begin
      step(rbit(), 1'b0, e_wait, FULL, "stall_forced");
      n_stall++;
    end
    k = 0;
    while (k < 20 && int'($urandom_range(99)) < stall_pct) begin
      step(rbit(), 1'b0, e_wait, FULL, "stall_rand");
      n_stall++;
      k++;
    end
    if (final_pt) begin
      step(rbit(), 1'b1, pk(1, 12 - rb, 0, 1, 1, !d, 1, 2, 1, b, 0, 0, 1, d), FULL, "pt_final");
    end else begin
      for (int r = 12 - rb; r <= 11; r++) begin
        acc = (r == 12 - rb);
        x   = ad_last && (r == 11);
        step(rbit(), acc ? 1'b1 : rbit(),
             pk(acc, r, 0, 1, 0, acc && !(is_pt && d), x, x ? 1 : 0, acc && is_pt, b, 0, 0, 1,
                acc && is_pt && d),
             FULL, is_pt ? "pt_block" : "ad_block");
      end
    end
  endtask

  // full message as seen from the control outputs, built from the protocol rules
  task automatic run_msg(input int s, input int ra, input int rb, input int nad, input int npt,
                         input int stall_pct, input int stall_blk, input int stall_n, input bit d);
    sel = s; cyc = 0; n_cv = 0; end_cyc = -1; n_stall = 0;
`ifdef ASCON_CTRL_DECRYPT_EN
    dec = d;
`endif
    step(1'b1, rbit(), 24'h0, FULL, "idle_start");
`ifdef ASCON_CTRL_DECRYPT_EN
    dec = !d;
`endif
    for (int r = 12 - ra; r <= 11; r++)
      step(rbit(), rbit(), pk(0, r, r == 12 - ra, 1, 0, 0, r == 11,
                              (r == 11 && nad == 0) ? 3 : 0, 0, 0, 0, 0, 1, 0), FULL, "perm_a");
    for (int b = 0; b < nad; b++)
      do_block(0, b, rb, b == nad - 1, 0, stall_pct, 0, d);
    for (int b = 0; b < npt; b++)
      do_block(1, b, rb, 0, b == npt - 1, stall_pct, (b == stall_blk) ? stall_n : 0, d);
    for (int r = 12 - ra; r <= 11; r++)
      step(rbit(), rbit(), pk(0, r, 0, 1, 0, 0, r == 11, 0, 0, npt - 1, 0, 0, 1, 0), FULL, "perm_f");
    step(rbit(), rbit(), pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0), DONE_MASK, "done");
    for (int i = 0; i < 3; i++)
      step(1'b0, rbit(), 24'h0, FULL, "idle_after");
    if (!aborted) begin
      check("end_cycle", 32'(end_cyc), 32'(2 + 2 * ra + (nad + npt - 1) * rb + n_stall));
      check("cv_count", 32'(n_cv), 32'(npt));
    end
  endtask

  initial begin
    resetb = 1'b0;
    dv = 1'b0;
    for (int i = 0; i < 3; i++) st[i] = 1'b0;
`ifdef ASCON_CTRL_DECRYPT_EN
    dec = 1'b0;
`endif
    #12;
    for (int i = 0; i < 3; i++) check("reset_state", {8'h0, obs[i]}, 32'h0);
    resetb = 1'b1;
    @(posedge clock_i);
    #1;

    // back-to-back defaults: DONE at cycle 50, four ciphertext pulses
    run_msg(0, 12, 6, 1, 4, 0, -1, 0, 0);
    // five-cycle stall in front of PT block 2
    run_msg(0, 12, 6, 1, 4, 0, 2, 5, 0);

    // reset in the middle of PERM_PT for block 1
    abort_at = 28;
    run_msg(0, 12, 6, 1, 4, 0, -1, 0, 0);
    check("abort_taken", 32'(aborted), 32'd1);
    dv = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clock_i);
      #1;
      check("reset_hold", {8'h0, obs[0]}, 32'h0);
    end
    resetb = 1'b1;
    aborted = 0;
    abort_at = -1;
    cyc = 0;
    for (int i = 0; i < 3; i++) step(1'b0, rbit(), 24'h0, FULL, "idle_post_reset");
    run_msg(0, 12, 6, 1, 4, 0, -1, 0, 0);

    // two AD blocks, ROUNDS_B=8, short init/final
    run_msg(1, 4, 8, 2, 3, 0, -1, 0, 0);
    // no associated data, single PT block
    run_msg(2, 12, 6, 0, 1, 0, -1, 0, 0);

    // randomized stall patterns on all three configurations
    for (int n = 0; n < 3; n++) begin
      run_msg(0, 12, 6, 1, 4, int'($urandom_range(60)), -1, 0, 0);
      run_msg(1, 4, 8, 2, 3, int'($urandom_range(60)), int'($urandom_range(2)), int'($urandom_range(4)), 0);
      run_msg(2, 12, 6, 0, 1, int'($urandom_range(60)), 0, int'($urandom_range(3)), 0);
    end

`ifdef ASCON_CTRL_DECRYPT_EN
    run_msg(0, 12, 6, 1, 4, 0, -1, 0, 1);
    run_msg(1, 4, 8, 2, 3, 30, -1, 0, 1);
    run_msg(2, 12, 6, 0, 1, 30, -1, 0, 1);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
